// File: rtl/prog_sequence_counter.sv
// prog_sequence_counter: steps through a run-time programmable table of
// WIDTH-bit codes, forward or backward, in wrap or one-shot mode, and
// pulses tc on each end-of-sequence step.
// Optional feature macro: SEQ_TOGGLE_EN adds the t_vec toggle-mask output.
module prog_sequence_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     dir,
  input  logic                     oneshot,
  input  logic                     restart,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     len_we,
  input  logic [$clog2(DEPTH):0]   len_val,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     tc,
  output logic                     done
`ifdef SEQ_TOGGLE_EN
  ,
  output logic [WIDTH-1:0]         t_vec
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] tbl [DEPTH];
  logic [AW:0]      len;
  logic [AW:0]      len_eff;
  logic [AW-1:0]    last;
  logic [AW-1:0]    next_idx;
  logic             len_ok;
  logic             clamp;
  logic             step;
  logic             at_end;

  // Step decode: a legal length write takes effect on the same edge, so the
  // end-of-sequence position is judged against the incoming length.
  always_comb begin
    len_ok   = len_we && (len_val != '0) && (len_val <= DEPTH_L);
    len_eff  = len_ok ? len_val : len;
    last     = AW'(len_eff - (AW+1)'(1));
    step     = en && !done && !restart;
    clamp    = len_ok && ({1'b0, idx} >= len_val);
    at_end   = dir ? (idx == '0) : (idx == last);
    next_idx = idx;
    if (!at_end) begin
      next_idx = dir ? (idx - AW'(1)) : (idx + AW'(1));
    end else if (!oneshot) begin
      next_idx = dir ? last : '0;
    end
  end

  // Current code is read straight from the table at the current index.
  always_comb begin
    q = tbl[idx];
  end

`ifdef SEQ_TOGGLE_EN
  // Bits of q that will flip on the coming edge if a step happens.
  always_comb begin
    t_vec = step ? (tbl[idx] ^ tbl[next_idx]) : '0;
  end
`endif

  // Index, length, terminal-count and done registers; restart beats the
  // length clamp, which beats a normal step.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      idx  <= '0;
      len  <= DEPTH_L;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      len <= len_eff;
      tc  <= 1'b0;
      if (restart) begin
        idx  <= dir ? last : '0;
        done <= 1'b0;
      end else if (clamp) begin
        idx <= '0;
      end else if (step) begin
        idx <= next_idx;
        tc  <= at_end;
        if (at_end && oneshot) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Code table: identity on clear, otherwise written independently of stepping.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= WIDTH'(i);
      end
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      tbl[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_prog_sequence_counter.sv
// Testbench for prog_sequence_counter (WIDTH=4, DEPTH=16).
module tb_prog_sequence_counter;

  logic       clk = 1'b0;
  logic       clear, en, dir, oneshot, restart, wr_en, len_we;
  logic [3:0] wr_addr, wr_data;
  logic [4:0] len_val;
  logic [3:0] q, idx;
  logic       tc, done;
`ifdef SEQ_TOGGLE_EN
  logic [3:0] t_vec;
`endif

  int total = 0;
  int bad   = 0;
  int tc_cnt;

  // Reference model state
  int         m_idx, m_len;
  bit         m_done, m_tc;
  logic [3:0] m_tbl [16];

  prog_sequence_counter #(.WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .clear(clear), .en(en), .dir(dir), .oneshot(oneshot),
    .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_val(len_val), .q(q), .idx(idx), .tc(tc), .done(done)
`ifdef SEQ_TOGGLE_EN
    , .t_vec(t_vec)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_idx = 0; m_len = 16; m_done = 0; m_tc = 0;
    for (int i = 0; i < 16; i++) m_tbl[i] = 4'(i);
  endfunction

  function automatic int m_eff_len();
    if (len_we && len_val >= 1 && len_val <= 16) return int'(len_val);
    return m_len;
  endfunction

  // Position after one step from m_idx for a sequence of lenv entries.
  function automatic int m_next(input int lenv);
    if (!dir) return (m_idx == lenv - 1) ? (oneshot ? m_idx : 0) : m_idx + 1;
    return (m_idx == 0) ? (oneshot ? m_idx : lenv - 1) : m_idx - 1;
  endfunction

  function automatic void m_edge();
    int  nl;
    bit  lok;
    nl  = m_eff_len();
    lok = len_we && len_val >= 1 && len_val <= 16;
    m_tc = 0;
    if (restart) begin
      m_idx  = dir ? nl - 1 : 0;
      m_done = 0;
    end else if (lok && m_idx >= nl) begin
      m_idx = 0;
    end else if (en && !m_done) begin
      m_tc  = dir ? (m_idx == 0) : (m_idx == nl - 1);
      m_idx = m_next(nl);
      if (m_tc && oneshot) m_done = 1;
    end
    m_len = nl;
    if (wr_en) m_tbl[wr_addr] = wr_data;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".q"},    32'(q),    32'(m_tbl[m_idx]));
    chk({tag, ".idx"},  32'(idx),  32'(m_idx));
    chk({tag, ".tc"},   32'(tc),   32'(m_tc));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // One clock: optional pre-edge t_vec check, model update, edge, output check.
  task automatic tick(input string tag);
`ifdef SEQ_TOGGLE_EN
    logic [3:0] exp_t;
    #1;
    exp_t = 4'b0;
    if (en && !m_done && !restart) exp_t = m_tbl[m_idx] ^ m_tbl[m_next(m_eff_len())];
    chk({tag, ".t_vec"}, 32'(t_vec), 32'(exp_t));
`endif
    m_edge();
    @(posedge clk);
    #1;
    if (tc) tc_cnt++;
    check_outs(tag);
  endtask

  task automatic idle();
    en = 0; dir = 0; oneshot = 0; restart = 0;
    wr_en = 0; wr_addr = '0; wr_data = '0; len_we = 0; len_val = '0;
  endtask

  // Asynchronous clear applied away from any clock edge.
  task automatic do_clear(input string tag);
    clear = 1;
    #1;
    m_reset();
    check_outs(tag);
    #1;
    clear = 0;
  endtask

  logic [3:0] prog [5];

  initial begin
    prog[0] = 4'd8; prog[1] = 4'd3; prog[2] = 4'd12; prog[3] = 4'd5; prog[4] = 4'd1;
    idle();
    clear = 1;
    m_reset();
    #1;
    check_outs("reset");
    @(posedge clk);
    #1;
    clear = 0;

    // Identity sequence wraps after 16 steps with a single tc pulse.
    tc_cnt = 0;
    en = 1;
    for (int i = 0; i < 17; i++) tick("wrap");
    chk("wrap_tc_count", 32'(tc_cnt), 32'd1);

    // Program 8,3,12,5,1 with length 5, then walk forward and backward.
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = prog[i];
      tick("prog_wr");
    end
    wr_en = 0; len_we = 1; len_val = 5'd5;
    tick("prog_len");
    len_we = 0; restart = 1;
    tick("prog_restart");
    restart = 0; en = 1;
    for (int i = 0; i < 5; i++) tick("prog_fwd");
    dir = 1;
    for (int i = 0; i < 4; i++) tick("prog_bwd");

    // One-shot run over three entries.
    idle();
    len_we = 1; len_val = 5'd3; restart = 1;
    tick("os_setup");
    idle();
    oneshot = 1; en = 1;
    tc_cnt = 0;
    for (int i = 0; i < 6; i++) tick("oneshot");
    chk("oneshot_tc_count", 32'(tc_cnt), 32'd1);
    chk("oneshot_done", 32'(done), 32'd1);
    oneshot = 0;
    tick("os_hold_after_mode_change");
    restart = 1;
    tick("os_restart");
    chk("os_restart_idx", 32'(idx), 32'd0);

    // Length shrink below current index overrides the step.
    idle();
    len_we = 1; len_val = 5'd16; restart = 1;
    tick("shr_setup");
    idle(); en = 1;
    for (int i = 0; i < 10; i++) tick("shr_walk");
    chk("shr_idx10", 32'(idx), 32'd10);
    len_we = 1; len_val = 5'd4;
    tick("shr_clamp");
    chk("shr_clamp_tc", 32'(tc), 32'd0);
    idle(); len_we = 1; len_val = 5'd0;
    tick("shr_len0");
    len_val = 5'd17;
    tick("shr_len17");
    idle(); en = 1;
    for (int i = 0; i < 5; i++) tick("shr_len4_walk");

    // Clear mid-sequence restores the identity table.
    idle();
    len_we = 1; len_val = 5'd16; restart = 1;
    tick("mid_setup");
    idle(); wr_en = 1; wr_addr = 4'd7; wr_data = 4'hf;
    tick("mid_wr");
    idle(); en = 1;
    for (int i = 0; i < 7; i++) tick("mid_walk");
    chk("mid_q_modified", 32'(q), 32'hf);
    do_clear("mid_clear");
    for (int i = 0; i < 16; i++) tick("mid_identity");

`ifdef SEQ_TOGGLE_EN
    idle();
    do_clear("tog_clear");
    wr_en = 1; wr_addr = 4'd0; wr_data = 4'b1010;
    tick("tog_wr0");
    wr_addr = 4'd1; wr_data = 4'b0110;
    tick("tog_wr1");
    idle(); en = 1;
    #1;
    chk("tog_step", 32'(t_vec), 32'b1100);
    en = 0;
    #1;
    chk("tog_idle", 32'(t_vec), 32'd0);
`endif

    // Randomised traffic against the model.
    idle();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      dir     = ($urandom_range(0, 3) == 0);
      oneshot = ($urandom_range(0, 7) == 0);
      restart = ($urandom_range(0, 15) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      len_we  = !en && !restart && ($urandom_range(0, 3) == 0);
      len_val = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) do_clear("rnd_clear");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
